// File: rtl/mul_pkg.sv
// Shared encodings for the iterative multiply unit: operation codes and FSM states.
package mul_pkg;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULH = 2'b01;
    localparam logic [1:0] OP_SMULH = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        WB   = 2'b11
    } state_e;

endpackage

// File: rtl/mul_unit.sv
// Radix-2 shift-add 64x64 multiplier (MUL/UMULH/SMULH) that returns its result
// as a single-cycle register file write request.
module mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int AW    = 5,
    parameter int XZR   = 31
) (
    input  logic             Clk,
    input  logic             ResetL,
    input  logic             Start,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [1:0]       Op,
    input  logic [AW-1:0]    Rd,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] BusW,
    output logic [AW-1:0]    RW,
    output logic             RegWr
);

    localparam int            CW = $clog2(WIDTH);
    localparam logic [AW-1:0] ZR = AW'(XZR);

    function automatic logic [WIDTH-1:0] abs_v(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_e             state;
    logic [1:0]         op_q;
    logic [AW-1:0]      rd_q;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic               high;

    // Upper half plus optional multiplicand; bit WIDTH is the carry that
    // shifts back into the top of the accumulator.
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    end

    always_comb begin
        high = (op_q == OP_UMULH) || (op_q == OP_SMULH);
        prod = acc;
        if (op_q == OP_SMULH && neg)
            prod = ~acc + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end

    assign Busy = (state != IDLE);

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            state  <= IDLE;
            op_q   <= OP_MUL;
            rd_q   <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            BusW   <= '0;
            RW     <= '0;
            Done   <= 1'b0;
            RegWr  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    op_q <= Op;
                    rd_q <= Rd;
                    if (Op == OP_SMULH) begin
                        mcand  <= abs_v(OpA);
                        mplier <= abs_v(OpB);
                        neg    <= OpA[WIDTH-1] ^ OpB[WIDTH-1];
                    end else begin
                        mcand  <= OpA;
                        mplier <= OpB;
                        neg    <= 1'b0;
                    end
                    acc   <= '0;
                    cnt   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    acc    <= {sum, acc[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1))
                        state <= FIX;
                end
                FIX: begin
                    acc   <= prod;
                    BusW  <= high ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
                    RW    <= rd_q;
                    state <= WB;
                end
                WB: begin
                    // First WB edge raises the write request, second retires it.
                    if (!Done) begin
                        Done  <= 1'b1;
                        RegWr <= (RW != ZR);
                    end else begin
                        Done  <= 1'b0;
                        RegWr <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed and random operations against a
// wide-arithmetic reference, latency/Busy/Done checks, restart and reset cases.
module tb_mul_unit;

    logic        Clk;
    logic        ResetL;
    logic        Start;
    logic [63:0] OpA;
    logic [63:0] OpB;
    logic [1:0]  Op;
    logic [4:0]  Rd;
    logic        Busy;
    logic        Done;
    logic [63:0] BusW;
    logic [4:0]  RW;
    logic        RegWr;

    int total  = 0;
    int passed = 0;

    mul_unit #(.WIDTH(64), .AW(5), .XZR(31)) dut (
        .Clk(Clk), .ResetL(ResetL), .Start(Start), .OpA(OpA), .OpB(OpB),
        .Op(Op), .Rd(Rd), .Busy(Busy), .Done(Done), .BusW(BusW), .RW(RW),
        .RegWr(RegWr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: full 128-bit product from plain arithmetic on the operands.
    function automatic logic [63:0] ref_res(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] op);
        logic [127:0] p;
        if (op == 2'b10)
            p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        else
            p = {64'b0, a} * {64'b0, b};
        return (op == 2'b01 || op == 2'b10) ? p[127:64] : p[63:0];
    endfunction

    task automatic rand64(output logic [63:0] v);
        v = {$urandom, $urandom};
    endtask

    // Issue one request and follow it for 71 cycles after the sampling edge.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] op, input logic [4:0] rd, input bit restart);
        logic [63:0] exp;
        int done_k, done_cnt, wr_cnt;
        exp = ref_res(a, b, op);
        done_k = -1; done_cnt = 0; wr_cnt = 0;
        @(negedge Clk);
        Start = 1'b1; OpA = a; OpB = b; Op = op; Rd = rd;
        @(posedge Clk);                      // edge T
        for (int k = 0; k <= 70; k++) begin
            @(negedge Clk);                  // cycle after edge T+k
            if (restart && (k + 1 == 10 || k + 1 == 66 || k + 1 == 67)) begin
                Start = 1'b1;
                rand64(OpA); rand64(OpB); Op = 2'($urandom_range(0, 3)); Rd = 5'd9;
            end else begin
                Start = 1'b0;
            end
            chk($sformatf("%s busy k=%0d", tag, k), 64'(Busy), 64'(k <= 66));
            if (Done === 1'b1) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k = k;
                    chk({tag, " regwr"}, 64'(RegWr), 64'(rd != 5'd31));
                    chk({tag, " busw"}, BusW, exp);
                    chk({tag, " rw"}, 64'(RW), 64'(rd));
                end
            end
            if (RegWr === 1'b1) wr_cnt++;
        end
        Start = 1'b0;
        chk({tag, " done_cycle"}, 64'(done_k), 64'd66);
        chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
        chk({tag, " wr_count"}, 64'(wr_cnt), 64'(rd != 5'd31));
        chk({tag, " busw_hold"}, BusW, exp);
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic [1:0]  rop;
        logic [4:0]  rrd;
        int          wr_cnt;
        Start = 1'b0; OpA = '0; OpB = '0; Op = 2'b00; Rd = '0;
        ResetL = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst busy", 64'(Busy), 64'd0);
        chk("rst done", 64'(Done), 64'd0);
        chk("rst regwr", 64'(RegWr), 64'd0);
        chk("rst busw", BusW, 64'd0);
        chk("rst rw", 64'(RW), 64'd0);
        ResetL = 1'b1;

        run_op("mul3x5", 64'd3, 64'd5, 2'b00, 5'd2, 1'b0);
        run_op("umulh_ff", '1, '1, 2'b01, 5'd4, 1'b0);
        run_op("mul_ff", '1, '1, 2'b00, 5'd5, 1'b0);
        run_op("smulh_m1x1", '1, 64'd1, 2'b10, 5'd6, 1'b0);
        run_op("smulh_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b10, 5'd7, 1'b0);
        run_op("mul_xzr", 64'd7, 64'd6, 2'b00, 5'd31, 1'b0);
        run_op("op11", 64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 2'b11, 5'd8, 1'b0);
        run_op("restart", 64'd11, 64'd13, 2'b00, 5'd3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            rand64(ra); rand64(rb);
            rop = 2'($urandom_range(0, 3));
            rrd = 5'($urandom_range(0, 31));
            run_op($sformatf("rand%0d", i), ra, rb, rop, rrd, 1'b0);
        end

        // Asynchronous abort in the middle of CALC.
        @(negedge Clk);
        Start = 1'b1; OpA = 64'd100; OpB = 64'd200; Op = 2'b00; Rd = 5'd10;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (29) @(negedge Clk);
        chk("pre_rst busy", 64'(Busy), 64'd1);
        #1 ResetL = 1'b0;
        #1;
        chk("arst busy", 64'(Busy), 64'd0);
        chk("arst done", 64'(Done), 64'd0);
        chk("arst regwr", 64'(RegWr), 64'd0);
        chk("arst busw", BusW, 64'd0);
        repeat (2) @(negedge Clk);
        ResetL = 1'b1;
        wr_cnt = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge Clk);
            if (RegWr === 1'b1 || Done === 1'b1) wr_cnt++;
        end
        chk("arst no_write", 64'(wr_cnt), 64'd0);
        run_op("post_rst", 64'hdead_beef, 64'h1_0000_0001, 2'b01, 5'd12, 1'b0);
        run_op("post_rst2", 64'hdead_beef, 64'h1_0000_0001, 2'b00, 5'd13, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
